// File: rtl/toggle_flip_flop_bank_arbiter.sv
// Bank of WIDTH toggle flip-flops shared by NUM_REQUESTERS clients.
// A round-robin arbiter accepts at most one command per cycle; the command
// toggles, sets, clears or reads one bit, and the served requester gets a
// one-cycle response carrying the post-operation bit value.
module toggle_flip_flop_bank_arbiter #(
  parameter int NUM_REQUESTERS = 4,
  parameter int WIDTH          = 8,
  localparam int INDEX_WIDTH   = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                                  clock,
  input  logic                                  resetn,
  input  logic                                  clear,
  input  logic [NUM_REQUESTERS-1:0]             request_valid,
  output logic [NUM_REQUESTERS-1:0]             request_ready,
  input  logic [2*NUM_REQUESTERS-1:0]           request_operation,
  input  logic [INDEX_WIDTH*NUM_REQUESTERS-1:0] request_index,
  output logic [NUM_REQUESTERS-1:0]             response_valid,
  output logic                                  response_state,
  output logic [WIDTH-1:0]                      state
);

  localparam int POINTER_WIDTH = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;

  typedef enum logic [1:0] {
    OP_TOGGLE = 2'b00,
    OP_SET    = 2'b01,
    OP_CLEAR  = 2'b10,
    OP_READ   = 2'b11
  } operation_e;

  // Round-robin pointer: the requester with highest priority this cycle.
  logic [POINTER_WIDTH-1:0] pointer;
  logic [POINTER_WIDTH-1:0] pointer_next;

  // Arbitration results.
  logic [NUM_REQUESTERS-1:0] grant_scan;
  logic                      grant_found;
  logic [POINTER_WIDTH-1:0]  grant_id;
  logic                      grant_enable;
  logic                      grant_any;

  // Command of the granted requester.
  operation_e                sel_operation;
  logic [INDEX_WIDTH-1:0]    sel_index;

  // Bank update and response data.
  logic                      index_in_range;
  logic                      bit_current;
  logic                      bit_next;
  logic                      response_bit;
  logic [WIDTH-1:0]          state_next;

  // Scan requesters starting at the pointer and pick the first valid one.
  always_comb begin
    // NOTE: every variable of a combinational block gets a default first so no latch is inferred.
    int                       candidate;
    logic [POINTER_WIDTH-1:0] candidate_id;
    grant_scan   = '0;
    grant_found  = 1'b0;
    grant_id     = '0;
    candidate    = 0;
    candidate_id = '0;
    for (int offset = 0; offset < NUM_REQUESTERS; offset++) begin
      candidate = int'(pointer) + offset;
      if (candidate >= NUM_REQUESTERS) begin
        candidate = candidate - NUM_REQUESTERS;
      end
      candidate_id = POINTER_WIDTH'(candidate);
      if (!grant_found && request_valid[candidate_id]) begin
        grant_found              = 1'b1;
        grant_id                 = candidate_id;
        grant_scan[candidate_id] = 1'b1;
      end
    end
  end

  // Clear and reset suppress every grant; the ready vector is the gated scan.
  always_comb begin
    grant_enable  = resetn && !clear;
    grant_any     = grant_found && grant_enable;
    request_ready = grant_enable ? grant_scan : '0;
  end

  // Route the granted requester's operation and index to the bank.
  always_comb begin
    sel_operation = OP_READ;
    sel_index     = '0;
    for (int r = 0; r < NUM_REQUESTERS; r++) begin
      if (grant_scan[r]) begin
        sel_operation = operation_e'(request_operation[2*r +: 2]);
        sel_index     = request_index[INDEX_WIDTH*r +: INDEX_WIDTH];
      end
    end
  end

  // Compute the post-operation bit; out-of-range indices leave the bank alone
  // and answer 0.
  always_comb begin
    index_in_range = (int'(sel_index) < WIDTH);
    bit_current    = index_in_range ? state[sel_index] : 1'b0;
    unique case (sel_operation)
      OP_TOGGLE: bit_next = ~bit_current;
      OP_SET:    bit_next = 1'b1;
      OP_CLEAR:  bit_next = 1'b0;
      default:   bit_next = bit_current;
    endcase
    response_bit = index_in_range ? bit_next : 1'b0;
    state_next   = state;
    if (grant_any && index_in_range) begin
      state_next[sel_index] = bit_next;
    end
  end

  // The pointer moves to the requester after the one just served.
  always_comb begin
    pointer_next = pointer;
    if (grant_any) begin
      if (grant_id == POINTER_WIDTH'(NUM_REQUESTERS - 1)) begin
        pointer_next = '0;
      end else begin
        pointer_next = grant_id + POINTER_WIDTH'(1);
      end
    end
  end

  // Arbitration pointer register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pointer <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      pointer <= pointer_next;
    end
  end

  // Bank register: clear wins over any command.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      // NOTE: the bank is a small set of flops, not a RAM, so it is reset with everything else.
      state <= '0;
    end else if (clear) begin
      state <= '0;
    end else begin
      state <= state_next;
    end
  end

  // One-cycle response to the requester served at this edge.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      response_valid <= '0;
      response_state <= 1'b0;
    end else begin
      response_valid <= request_ready;
      response_state <= grant_any ? response_bit : 1'b0;
    end
  end

endmodule

// File: tb/tb_toggle_flip_flop_bank_arbiter.sv
// Self-checking bench for toggle_flip_flop_bank_arbiter: a bank/pointer model
// checked every cycle, directed scenarios with literal expectations, a random
// phase, and a second single-requester instance with a non-power-of-two bank.
module tb_toggle_flip_flop_bank_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 3;

  localparam logic [1:0] TOGGLE = 2'b00;
  localparam logic [1:0] SET    = 2'b01;
  localparam logic [1:0] CLR    = 2'b10;
  localparam logic [1:0] READ   = 2'b11;

  logic            clock;
  logic            resetn;
  logic            clear;
  logic [N-1:0]    request_valid;
  logic [N-1:0]    request_ready;
  logic [2*N-1:0]  request_operation;
  logic [IW*N-1:0] request_index;
  logic [N-1:0]    response_valid;
  logic            response_state;
  logic [W-1:0]    state;

  // Single-requester instance with a 6-bit bank.
  logic       s_clear;
  logic       s_valid;
  logic       s_ready;
  logic [1:0] s_op;
  logic [2:0] s_idx;
  logic       s_rv;
  logic       s_rs;
  logic [5:0] s_state;

  int n_checks = 0;
  int n_fail   = 0;

  toggle_flip_flop_bank_arbiter #(.NUM_REQUESTERS(N), .WIDTH(W)) u_dut (
    .clock             (clock),
    .resetn            (resetn),
    .clear             (clear),
    .request_valid     (request_valid),
    .request_ready     (request_ready),
    .request_operation (request_operation),
    .request_index     (request_index),
    .response_valid    (response_valid),
    .response_state    (response_state),
    .state             (state)
  );

  toggle_flip_flop_bank_arbiter #(.NUM_REQUESTERS(1), .WIDTH(6)) u_small (
    .clock             (clock),
    .resetn            (resetn),
    .clear             (s_clear),
    .request_valid     (s_valid),
    .request_ready     (s_ready),
    .request_operation (s_op),
    .request_index     (s_idx),
    .response_valid    (s_rv),
    .response_state    (s_rs),
    .state             (s_state)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model: a bit array plus an integer round-robin pointer.
  // ---------------------------------------------------------------------
  bit       m_bank [W];
  int       m_ptr;
  logic [N-1:0] m_rv;
  logic     m_rs;

  // Requester that wins this cycle, or -1 when nobody may be served.
  function automatic int pick(input int ptr, input logic [N-1:0] v, input logic clr, input logic rn);
    if (!rn || clr) return -1;
    for (int k = 0; k < N; k++) begin
      int r;
      r = (ptr + k) % N;
      if (v[r]) return r;
    end
    return -1;
  endfunction

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < W; i++) m_bank[i] = 1'b0;
      m_ptr = 0;
      m_rv  = '0;
      m_rs  = 1'b0;
    end else begin
      int g;
      int idx;
      logic [1:0] op;
      g    = pick(m_ptr, request_valid, clear, resetn);
      m_rv = '0;
      if (g >= 0) begin
        op  = request_operation[2*g +: 2];
        idx = int'(request_index[IW*g +: IW]);
        if (idx < W) begin
          case (op)
            TOGGLE:  m_bank[idx] = !m_bank[idx];
            SET:     m_bank[idx] = 1'b1;
            CLR:     m_bank[idx] = 1'b0;
            default: m_bank[idx] = m_bank[idx];
          endcase
          m_rs = m_bank[idx];
        end else begin
          m_rs = 1'b0;
        end
        m_rv[g] = 1'b1;
        m_ptr   = (g + 1) % N;
      end
      if (clear) begin
        for (int i = 0; i < W; i++) m_bank[i] = 1'b0;
      end
    end
  end

  // Compare DUT against the model on every falling edge.
  always @(negedge clock) begin
    logic [W-1:0] m_state;
    logic [N-1:0] exp_ready;
    int g;
    for (int i = 0; i < W; i++) m_state[i] = m_bank[i];
    exp_ready = '0;
    g = pick(m_ptr, request_valid, clear, resetn);
    if (g >= 0) exp_ready[g] = 1'b1;
    check("model_state", 32'(state), 32'(m_state));
    check("model_response_valid", 32'(response_valid), 32'(m_rv));
    if (m_rv != '0) check("model_response_state", 32'(response_state), 32'(m_rs));
    check("model_request_ready", 32'(request_ready), 32'(exp_ready));
    check("ready_onehot0", 32'($onehot0(request_ready)), 32'd1);
  end

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  task automatic set_req(input int r, input logic v, input logic [1:0] op, input logic [2:0] idx);
    request_valid[r]             = v;
    request_operation[2*r +: 2]  = op;
    request_index[IW*r +: IW]    = idx;
  endtask

  initial begin
    logic [N-1:0] hs;
    resetn            = 1'b0;
    clear             = 1'b0;
    request_valid     = '0;
    request_operation = '0;
    request_index     = '0;
    s_clear           = 1'b0;
    s_valid           = 1'b0;
    s_op              = TOGGLE;
    s_idx             = 3'd0;

    // Reset state.
    repeat (2) tick();
    resetn = 1'b1;
    mid();
    check("reset_state", 32'(state), 32'h00);
    check("reset_response_valid", 32'(response_valid), 32'h0);
    check("reset_ready", 32'(request_ready), 32'h0);

    // Requester 0 toggles index 3 three times back-to-back.
    tick();
    set_req(0, 1'b1, TOGGLE, 3'd3);
    mid();
    check("toggle_ready", 32'(request_ready), 32'b0001);
    tick();
    mid();
    check("toggle1_state", 32'(state), 32'h08);
    check("toggle1_rv", 32'(response_valid), 32'b0001);
    check("toggle1_rs", 32'(response_state), 32'd1);
    tick();
    mid();
    check("toggle2_state", 32'(state), 32'h00);
    check("toggle2_rs", 32'(response_state), 32'd0);
    tick();
    set_req(0, 1'b0, TOGGLE, 3'd3);
    mid();
    check("toggle3_state", 32'(state), 32'h08);
    check("toggle3_rv", 32'(response_valid), 32'b0001);
    check("toggle3_rs", 32'(response_state), 32'd1);
    tick();
    mid();
    check("idle_rv", 32'(response_valid), 32'h0);

    // Reset in the middle of a handshake drops the pending response.
    #1;
    set_req(1, 1'b1, TOGGLE, 3'd6);
    tick();
    resetn = 1'b0;
    #1;
    check("async_reset_state", 32'(state), 32'h00);
    check("async_reset_rv", 32'(response_valid), 32'h0);
    check("async_reset_ready", 32'(request_ready), 32'h0);
    tick();
    tick();
    resetn = 1'b1;
    mid();
    check("rearb_ready", 32'(request_ready), 32'b0010);
    #1;
    for (int r = 0; r < N; r++) set_req(r, 1'b1, TOGGLE, 3'(r));

    // All requesters continuously valid: strict rotation 0,1,2,3.
    for (int cyc = 1; cyc <= 8; cyc++) begin
      tick();
      mid();
      check("rr_grant", 32'(response_valid), 32'(1 << ((cyc - 1) % N)));
      if (cyc == 4) check("rr_state_4", 32'(state), 32'h0F);
      if (cyc == 8) check("rr_state_8", 32'(state), 32'h00);
    end
    #1;
    for (int r = 0; r < N; r++) set_req(r, 1'b0, TOGGLE, 3'd0);

    // Move the pointer to 1, then a read and a set race for index 5.
    set_req(0, 1'b1, READ, 3'd0);
    tick();
    set_req(0, 1'b0, READ, 3'd0);
    set_req(1, 1'b1, READ, 3'd5);
    set_req(2, 1'b1, SET, 3'd5);
    mid();
    check("ptr1_ready", 32'(request_ready), 32'b0010);
    tick();
    set_req(1, 1'b0, READ, 3'd5);
    mid();
    check("race_read_rv", 32'(response_valid), 32'b0010);
    check("race_read_rs", 32'(response_state), 32'd0);
    tick();
    set_req(2, 1'b0, SET, 3'd5);
    mid();
    check("race_set_rv", 32'(response_valid), 32'b0100);
    check("race_set_rs", 32'(response_state), 32'd1);
    check("race_set_state", 32'(state), 32'h20);

    // Build 0xA5, then clear while everyone is requesting.
    #1;
    set_req(3, 1'b1, SET, 3'd0);
    tick();
    set_req(3, 1'b1, SET, 3'd2);
    tick();
    set_req(3, 1'b1, SET, 3'd7);
    tick();
    clear = 1'b1;
    for (int r = 0; r < N; r++) set_req(r, 1'b1, TOGGLE, 3'(r + 4));
    mid();
    check("clear_ready", 32'(request_ready), 32'h0);
    check("clear_pre_state", 32'(state), 32'hA5);
    check("clear_pending_rv", 32'(response_valid), 32'b1000);
    check("clear_pending_rs", 32'(response_state), 32'd1);
    tick();
    clear = 1'b0;
    mid();
    check("clear_state", 32'(state), 32'h00);
    check("clear_no_rv", 32'(response_valid), 32'h0);
    check("clear_resume_ready", 32'(request_ready), 32'b0001);
    repeat (6) tick();
    for (int r = 0; r < N; r++) set_req(r, 1'b0, TOGGLE, 3'd0);

    // Random traffic obeying the hold-until-handshake rule.
    for (int cyc = 0; cyc < 1000; cyc++) begin
      mid();
      hs = request_valid & request_ready;
      tick();
      for (int r = 0; r < N; r++) begin
        if (!request_valid[r] || hs[r]) begin
          set_req(r, ($urandom_range(0, 2) != 0), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
        end
      end
      clear = ($urandom_range(0, 15) == 0);
      if (cyc == 500) resetn = 1'b0;
      if (cyc == 503) resetn = 1'b1;
    end
    clear = 1'b0;
    for (int r = 0; r < N; r++) set_req(r, 1'b0, TOGGLE, 3'd0);
    tick();

    // Single requester, 6-bit bank: out-of-range index and clear gating.
    s_valid = 1'b1;
    s_op    = TOGGLE;
    s_idx   = 3'd6;
    mid();
    check("small_ready", 32'(s_ready), 32'd1);
    tick();
    s_op  = SET;
    s_idx = 3'd5;
    mid();
    check("small_oob_state", 32'(s_state), 32'h00);
    check("small_oob_rv", 32'(s_rv), 32'd1);
    check("small_oob_rs", 32'(s_rs), 32'd0);
    tick();
    s_clear = 1'b1;
    mid();
    check("small_set_state", 32'(s_state), 32'h20);
    check("small_set_rs", 32'(s_rs), 32'd1);
    check("small_clear_ready", 32'(s_ready), 32'd0);
    tick();
    s_clear = 1'b0;
    s_valid = 1'b0;
    mid();
    check("small_clear_state", 32'(s_state), 32'h00);
    check("small_clear_rv", 32'(s_rv), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
